// File: rtl/wos_window_core.sv
// Sliding-window weighted order-statistic core: circular column buffer plus an
// MSB-first bit-serial threshold search over a snapshot of the current window.
`timescale 1ns/1ps
module wos_window_core #(
    parameter int WORD  = 8,
    parameter int MAX_K = 5,
    parameter int WW    = 4,
    parameter int SW    = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] n,
    input  logic            s_valid,
    input  logic [WORD-1:0] s_data,
    input  logic            s_inside,
    input  logic            line_clr,
    input  logic            win_req,
    input  logic [SW-1:0]   thr,
    input  logic            wgt_we,
    input  logic [4:0]      wgt_addr,
    input  logic [WW-1:0]   wgt_data,
    output logic            res_valid,
    output logic [WORD-1:0] res_data,
    output logic            busy,
    output logic            overrun
);
    localparam int NE = MAX_K * MAX_K;
    localparam int NW = $clog2(MAX_K + 1);
    localparam int IW = $clog2(NE);
    localparam int BW = $clog2(WORD);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [NW-1:0]   r_n, r_wrow, r_wcol;
    logic [NW-1:0]   w_n_sat, w_n_cur, w_row_cur, w_col_cur, w_row_nxt, w_col_nxt;
    logic [IW-1:0]   w_wr_idx;
    logic [WORD-1:0] r_buf_data [NE];
    logic [NE-1:0]   r_buf_in, w_in_nxt;
    logic [WW-1:0]   r_wgt [NE];
    logic [WORD-1:0] r_snap_d [NE];
    logic [WW-1:0]   r_snap_w [NE];
    logic [WORD-1:0] w_snap_d [NE];
    logic [WW-1:0]   w_snap_w [NE];
    logic [SW-1:0]   r_thr, w_sum;
    logic [WORD-1:0] r_cand, w_test, r_res_data;
    logic [BW-1:0]   r_bit;
    logic            r_res_valid, r_ovr;
    logic            w_load, w_step, w_finish, w_ovr;

    // A line clear takes effect before a same-cycle sample, so the write uses the new n and origin.
    always_comb begin
        if (n == '0)                 w_n_sat = NW'(1);
        else if (n > WORD'(MAX_K))   w_n_sat = NW'(MAX_K);
        else                         w_n_sat = n[NW-1:0];
        w_n_cur   = line_clr ? w_n_sat : r_n;
        w_row_cur = line_clr ? '0 : r_wrow;
        w_col_cur = line_clr ? '0 : r_wcol;
        w_wr_idx  = IW'(w_col_cur) * IW'(MAX_K) + IW'(w_row_cur);
        w_row_nxt = w_row_cur;
        w_col_nxt = w_col_cur;
        w_in_nxt  = line_clr ? '0 : r_buf_in;
        if (s_valid) begin
            w_in_nxt[w_wr_idx] = s_inside;
            if (w_row_cur == w_n_cur - NW'(1)) begin
                w_row_nxt = '0;
                w_col_nxt = (w_col_cur == w_n_cur - NW'(1)) ? '0 : w_col_cur + NW'(1);
            end else begin
                w_row_nxt = w_row_cur + NW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n      <= NW'(1);
            r_wrow   <= '0;
            r_wcol   <= '0;
            r_buf_in <= '0;
        end else begin
            r_n      <= w_n_cur;
            r_wrow   <= w_row_nxt;
            r_wcol   <= w_col_nxt;
            r_buf_in <= w_in_nxt;
        end
    end

    // NOTE: pixel storage is deliberately not reset; stale values are masked by the cleared inside bits.
    always_ff @(posedge clk) begin
        if (s_valid) r_buf_data[w_wr_idx] <= s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NE; i++) r_wgt[i] <= WW'(1);
        end else if (wgt_we && (int'(wgt_addr) < NE)) begin
            r_wgt[wgt_addr[IW-1:0]] <= wgt_data;
        end
    end

    // Reorder the circular buffer into logical (oldest-first) order and fold in padding exclusion.
    always_comb begin
        int pc, bi, wi;
        pc = 0;
        bi = 0;
        wi = 0;
        for (int i = 0; i < NE; i++) begin
            w_snap_d[i] = '0;
            w_snap_w[i] = '0;
        end
        for (int c = 0; c < MAX_K; c++) begin
            for (int r = 0; r < MAX_K; r++) begin
                pc = c + int'(r_wcol);
                if (pc >= int'(r_n)) pc = pc - int'(r_n);
                bi = pc * MAX_K + r;
                wi = r * int'(r_n) + c;
                if ((c < int'(r_n)) && (r < int'(r_n))) begin
                    w_snap_d[IW'(r * MAX_K + c)] = r_buf_data[IW'(bi)];
                    w_snap_w[IW'(r * MAX_K + c)] = r_buf_in[IW'(bi)] ? r_wgt[IW'(wi)] : '0;
                end
            end
        end
    end

    always_comb begin
        w_test = r_cand | (WORD'(1) << r_bit);
        w_sum  = '0;
        for (int i = 0; i < NE; i++) begin
            if (r_snap_d[i] >= w_test) w_sum = w_sum + SW'(r_snap_w[i]);
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        w_ovr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (win_req) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_step = 1'b1;
                w_ovr  = win_req;
                if (r_bit == '0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_finish    = 1'b1;
                w_ovr       = win_req;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_ovr       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_res_valid <= w_finish;
            if (w_finish) r_res_data <= r_cand;
            if (w_ovr)    r_ovr      <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_snap_d <= w_snap_d;
            r_snap_w <= w_snap_w;
            r_thr    <= thr;
            r_cand   <= '0;
            r_bit    <= BW'(WORD - 1);
        end else if (w_step) begin
            if (w_sum >= r_thr) r_cand <= w_test;
            r_bit <= r_bit - BW'(1);
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign busy      = (r_state != S_IDLE);
    assign overrun   = r_ovr;
endmodule

// File: tb/tb_wos_window_core.sv
// Directed bench for wos_window_core: stimulus pushes expected results into a
// queue, an independent monitor pops and compares on every res_valid.
`timescale 1ns/1ps
module tb_wos_window_core;
    localparam int WORD = 8, MAX_K = 5, WW = 4, SW = 10;

    logic            clk = 1'b0, rst = 1'b0;
    logic [WORD-1:0] n = 8'd3, s_data = '0;
    logic            s_valid = 1'b0, s_inside = 1'b0, line_clr = 1'b0, win_req = 1'b0;
    logic [SW-1:0]   thr = '0;
    logic            wgt_we = 1'b0;
    logic [4:0]      wgt_addr = '0;
    logic [WW-1:0]   wgt_data = '0;
    logic            res_valid, busy, overrun;
    logic [WORD-1:0] res_data;

    wos_window_core #(.WORD(WORD), .MAX_K(MAX_K), .WW(WW), .SW(SW)) dut (
        .clk(clk), .rst(rst), .n(n), .s_valid(s_valid), .s_data(s_data),
        .s_inside(s_inside), .line_clr(line_clr), .win_req(win_req), .thr(thr),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .res_valid(res_valid), .res_data(res_data), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD-1:0] data;
        int              cyc;
        string           name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_err = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: result strobes must match queued expectations, 10 cycles after the request.
    always @(negedge clk) begin
        exp_t e;
        if (rst && res_valid) begin
            check("res_valid_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check(e.name, res_data, e.data);
                check({e.name, "_latency"}, cyc - e.cyc, 10);
            end
        end
    end

    task automatic clr_in();
        s_valid  = 1'b0;
        line_clr = 1'b0;
        win_req  = 1'b0;
        wgt_we   = 1'b0;
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(negedge clk);
            clr_in();
        end
    endtask

    task automatic send(input logic [WORD-1:0] d, input logic ins, input logic clr, input logic [WORD-1:0] nn);
        @(negedge clk);
        clr_in();
        s_valid  = 1'b1;
        s_data   = d;
        s_inside = ins;
        line_clr = clr;
        n        = nn;
    endtask

    task automatic wr_wgt(input logic [4:0] a, input logic [WW-1:0] v);
        @(negedge clk);
        clr_in();
        wgt_we   = 1'b1;
        wgt_addr = a;
        wgt_data = v;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 9; i++) send(WORD'(10 * (i + 1)), 1'b1, i == 0, 8'd3);
    endtask

    task automatic do_win(input logic [SW-1:0] t, input logic [WORD-1:0] expv, input string name,
                          input logic smp = 1'b0, input logic [WORD-1:0] sd = '0);
        int bcnt;
        exp_t e;
        @(negedge clk);
        clr_in();
        win_req = 1'b1;
        thr     = t;
        if (smp) begin
            s_valid  = 1'b1;
            s_data   = sd;
            s_inside = 1'b1;
        end
        e.data = expv;
        e.cyc  = cyc;
        e.name = name;
        q.push_back(e);
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            clr_in();
            if (busy) bcnt++;
        end
        check({name, "_busy_cycles"}, bcnt, 9);
    endtask

    initial begin
        exp_t e;
        #23 rst = 1'b1;
        @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);

        // Abort a computation with async reset; a second request sets overrun first.
        @(negedge clk); clr_in(); win_req = 1'b1; thr = 10'd1;
        @(negedge clk); clr_in();
        @(negedge clk); clr_in(); win_req = 1'b1;
        @(negedge clk); clr_in();
        check("ovr_before_reset", overrun, 1);
        @(negedge clk); clr_in();
        #2 rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_overrun", overrun, 0);
        check("abort_res_valid", res_valid, 0);
        @(negedge clk); rst = 1'b1;
        tick(14);
        check("abort_idle_after", busy, 0);

        // 3x3 ramp 10..90, unit weights, then a heavy centre weight.
        load_ramp();
        do_win(10'd5, 8'd50, "ramp_t5");
        wr_wgt(5'd4, 4'd5);
        do_win(10'd9, 8'd50, "centre_t9");
        do_win(10'd10, 8'd40, "centre_t10");
        wr_wgt(5'd4, 4'd1);

        // Padded oldest column holding 255 must not count.
        for (int i = 0; i < 3; i++) send(8'd255, 1'b0, i == 0, 8'd3);
        for (int i = 1; i <= 6; i++) send(WORD'(i), 1'b1, 1'b0, 8'd3);
        do_win(10'd1, 8'd6, "pad_t1");
        do_win(10'd7, 8'd0, "pad_t7_short");
        do_win(10'd0, 8'd255, "pad_t0");

        // Same-cycle sample is excluded; then the window slides onto the new column.
        load_ramp();
        do_win(10'd5, 8'd50, "same_cycle", 1'b1, 8'd200);
        send(8'd200, 1'b1, 1'b0, 8'd3);
        send(8'd200, 1'b1, 1'b0, 8'd3);
        do_win(10'd5, 8'd80, "slide_t5");
        wr_wgt(5'd6, 4'd10);
        do_win(10'd10, 8'd60, "slide_map");
        wr_wgt(5'd6, 4'd1);

        // Overlapping request is dropped; line clear during busy leaves the snapshot intact.
        @(negedge clk); clr_in(); win_req = 1'b1; thr = 10'd5;
        e.data = 8'd80; e.cyc = cyc; e.name = "overrun_run"; q.push_back(e);
        tick(2);
        @(negedge clk); clr_in(); win_req = 1'b1; thr = 10'd1;
        @(negedge clk); clr_in(); line_clr = 1'b1; n = 8'd3;
        tick(1);
        check("overrun_set", overrun, 1);
        tick(10);
        check("overrun_sticky", overrun, 1);
        do_win(10'd1, 8'd0, "after_clr_empty");
        check("overrun_still", overrun, 1);

        // n=0 behaves as a 1x1 window.
        send(8'd77, 1'b1, 1'b1, 8'd0);
        do_win(10'd1, 8'd77, "n0_first");
        send(8'd33, 1'b1, 1'b0, 8'd0);
        do_win(10'd1, 8'd33, "n0_second");

        // n=9 saturates to 5x5.
        for (int i = 1; i <= 25; i++) send(WORD'(i), 1'b1, i == 1, 8'd9);
        do_win(10'd1, 8'd25, "sat_t1");
        do_win(10'd25, 8'd1, "sat_t25");
        do_win(10'd26, 8'd0, "sat_t26");

        tick(5);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
